// File: rtl/intra_mode_decide_writer.sv
// intra_mode_decide_writer
//   Takes one macroblock's per-mode SAD set and picks the lowest SAD, one
//   compare per cycle (ties keep the lower index). It then fetches the chosen
//   mode's residue block one row per beat and writes each row to the frame
//   residue memory at its raster pixel address. Finally it reports the chosen
//   mode together with its SAD and macroblock number.
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          SAD set handshake; sads (mode k at [k*SAD_W +: SAD_W]), mbnumber
//   res_sel                    mode whose residue rows are requested (stable in FETCH)
//   res_valid/res_ready        residue row handshake; res_row (pixel j at [j*RES_W +: RES_W])
//   wr_en, wr_addr, wr_data    residue memory write, one row per strobe
//   mode_valid, mode, mode_sad, mode_mbnum   decision report (pulse, values held)
//   err_mbnum                  pulse: mbnumber out of range, SAD set dropped
module intra_mode_decide_writer #(
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  parameter int MB_W    = 16,
  parameter int MB_H    = 16,
  parameter int N_MODES = 4,
  parameter int SAD_W   = 16,
  parameter int RES_W   = 9,
  parameter int MBNUM_W = 12,
  parameter int ADDR_W  = 20,
  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_MODES*SAD_W-1:0] sads,
  input  logic [MBNUM_W-1:0]       mbnumber,
  output logic [MODE_W-1:0]        res_sel,
  output logic                     res_ready,
  input  logic                     res_valid,
  input  logic [MB_W*RES_W-1:0]    res_row,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [MB_W*RES_W-1:0]    wr_data,
  output logic                     mode_valid,
  output logic [MODE_W-1:0]        mode,
  output logic [SAD_W-1:0]         mode_sad,
  output logic [MBNUM_W-1:0]       mode_mbnum,
  output logic                     err_mbnum
);

  localparam int          MBX   = FRAME_W / MB_W;
  localparam int unsigned MBS   = MBX * (FRAME_H / MB_H);
  localparam int          ROW_W = $clog2(MB_H);
  localparam int          NSLOT = 2 ** MODE_W;

  localparam logic [ADDR_W-1:0] MBX_A     = ADDR_W'(MBX);
  localparam logic [ADDR_W-1:0] MB_W_A    = ADDR_W'(MB_W);
  localparam logic [ADDR_W-1:0] FRAME_W_A = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] MBROW_A   = ADDR_W'(MB_H * FRAME_W);

  typedef enum logic [1:0] {IDLE, CMP, FETCH, DONE} state_t;

  state_t              state;
  logic [SAD_W-1:0]    sad_q [NSLOT];
  logic [MODE_W-1:0]   best;
  logic [MODE_W-1:0]   idx;
  logic [MBNUM_W-1:0]  mbnum_q;
  logic [ROW_W-1:0]    row;
  logic [ADDR_W-1:0]   row_addr;

  logic [ADDR_W-1:0]   mbn_a;
  logic [ADDR_W-1:0]   base_addr;
  logic [MODE_W-1:0]   cmp_best;
  logic                accept;
  logic                mb_ok;

  always_comb begin
    mbn_a     = ADDR_W'(mbnumber);
    // Top-left pixel of the MB; later rows just add FRAME_W per beat.
    base_addr = (mbn_a / MBX_A) * MBROW_A + (mbn_a % MBX_A) * MB_W_A;
    cmp_best  = (sad_q[idx] < sad_q[best]) ? idx : best;
    accept    = in_valid && in_ready;
    mb_ok     = 32'(mbnumber) < MBS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      res_ready  <= 1'b0;
      res_sel    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mode_valid <= 1'b0;
      mode       <= '0;
      mode_sad   <= '0;
      mode_mbnum <= '0;
      err_mbnum  <= 1'b0;
      best       <= '0;
      idx        <= '0;
      mbnum_q    <= '0;
      row        <= '0;
      row_addr   <= '0;
      for (int unsigned k = 0; k < NSLOT; k++) sad_q[k] <= '0;
    end else begin
      wr_en      <= 1'b0;
      mode_valid <= 1'b0;
      err_mbnum  <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (!mb_ok) begin
              err_mbnum <= 1'b1;
            end else begin
              for (int unsigned k = 0; k < N_MODES; k++)
                sad_q[k] <= sads[k*SAD_W +: SAD_W];
              mbnum_q  <= mbnumber;
              best     <= '0;
              idx      <= MODE_W'(1);
              row      <= '0;
              row_addr <= base_addr;
              in_ready <= 1'b0;
              if (N_MODES == 1) begin
                state     <= FETCH;
                res_ready <= 1'b1;
                res_sel   <= '0;
              end else begin
                state <= CMP;
              end
            end
          end
        end
        CMP: begin
          best <= cmp_best;
          idx  <= idx + MODE_W'(1);
          if (idx == MODE_W'(N_MODES - 1)) begin
            state     <= FETCH;
            res_ready <= 1'b1;
            res_sel   <= cmp_best;
          end
        end
        FETCH: begin
          if (res_valid && res_ready) begin
            wr_en    <= 1'b1;
            wr_data  <= res_row;
            wr_addr  <= row_addr;
            row_addr <= row_addr + FRAME_W_A;
            row      <= row + ROW_W'(1);
            if (row == ROW_W'(MB_H - 1)) begin
              state      <= DONE;
              res_ready  <= 1'b0;
              mode_valid <= 1'b1;
              mode       <= best;
              mode_sad   <= sad_q[best];
              mode_mbnum <= mbnum_q;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra_mode_decide_writer.sv
module tb_intra_mode_decide_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // DUT A: default parameters
  logic         in_valid, in_ready;
  logic [63:0]  sads;
  logic [11:0]  mbnumber;
  logic [1:0]   res_sel, mode;
  logic         res_ready, res_valid;
  logic [143:0] res_row, wr_data;
  logic         wr_en, mode_valid, err_mbnum;
  logic [19:0]  wr_addr;
  logic [15:0]  mode_sad;
  logic [11:0]  mode_mbnum;

  // DUT B: single mode, 8x8 macroblocks
  logic         in_valid_b, in_ready_b;
  logic [15:0]  sads_b;
  logic [11:0]  mbnumber_b;
  logic [0:0]   res_sel_b, mode_b;
  logic         res_ready_b, res_valid_b;
  logic [71:0]  res_row_b, wr_data_b;
  logic         wr_en_b, mode_valid_b, err_mbnum_b;
  logic [19:0]  wr_addr_b;
  logic [15:0]  mode_sad_b;
  logic [11:0]  mode_mbnum_b;

  intra_mode_decide_writer #(
    .FRAME_W(1280), .FRAME_H(720), .MB_W(16), .MB_H(16), .N_MODES(4),
    .SAD_W(16), .RES_W(9), .MBNUM_W(12), .ADDR_W(20)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sads(sads), .mbnumber(mbnumber), .res_sel(res_sel), .res_ready(res_ready),
    .res_valid(res_valid), .res_row(res_row), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .mode_valid(mode_valid), .mode(mode), .mode_sad(mode_sad),
    .mode_mbnum(mode_mbnum), .err_mbnum(err_mbnum)
  );

  intra_mode_decide_writer #(
    .FRAME_W(1280), .FRAME_H(720), .MB_W(8), .MB_H(8), .N_MODES(1),
    .SAD_W(16), .RES_W(9), .MBNUM_W(12), .ADDR_W(20)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .sads(sads_b), .mbnumber(mbnumber_b), .res_sel(res_sel_b), .res_ready(res_ready_b),
    .res_valid(res_valid_b), .res_row(res_row_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .mode_valid(mode_valid_b), .mode(mode_b), .mode_sad(mode_sad_b),
    .mode_mbnum(mode_mbnum_b), .err_mbnum(err_mbnum_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    int mode;
    int sad;
    int mbn;
  } dec_t;

  dec_t exp_q[$];
  int   s[4];
  int   cur_mode, mb_x, mb_y, mrow;
  int   mb_wr_count, tot_wr, mv_count, err_count, exp_err;
  int   first_addr, last_addr;
  bit   mon_en = 1'b0;
  bit   pend_wr = 1'b0;
  int   pend_addr;
  logic [143:0] pend_data;
  int   gap = 0;

  // residue source: 0 = always valid, 1 = alternate cycles, 2 = random
  initial begin
    res_valid = 1'b0;
    res_row   = '0;
    forever begin
      step();
      case (gap)
        0:       res_valid = 1'b1;
        1:       res_valid = ~res_valid;
        default: res_valid = 1'($urandom_range(0, 1));
      endcase
      for (int j = 0; j < 16; j++) res_row[j*9 +: 9] = 9'($urandom);
    end
  end

  // compare process for DUT A
  always @(negedge clk) begin
    if (mon_en) begin
      check("wr_en", wr_en, pend_wr);
      if (pend_wr && wr_en === 1'b1) begin
        check("wr_addr", wr_addr, pend_addr);
        check("wr_data", wr_data, pend_data);
      end
      if (wr_en === 1'b1) begin
        if (mb_wr_count == 0) first_addr = int'(wr_addr);
        last_addr = int'(wr_addr);
        mb_wr_count++;
        tot_wr++;
      end
      pend_wr = 1'b0;
      if (!reset && res_valid && res_ready === 1'b1) begin
        pend_wr   = 1'b1;
        pend_addr = (mb_y * 16 + mrow) * 1280 + mb_x * 16;
        pend_data = res_row;
        mrow++;
      end
      if (res_ready === 1'b1) check("res_sel", res_sel, cur_mode);
      if (mode_valid === 1'b1) begin
        mv_count++;
        check("mode_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          dec_t d;
          d = exp_q.pop_front();
          check("mode", mode, d.mode);
          check("mode_sad", mode_sad, d.sad);
          check("mode_mbnum", mode_mbnum, d.mbn);
          check("rows_before_mode", mrow, 16);
        end
      end
      if (err_mbnum === 1'b1) err_count++;
    end
  end

  // DUT B observation
  int wb_count, wb_first, wb_last;
  always @(negedge clk) begin
    if (mon_en && wr_en_b === 1'b1) begin
      if (wb_count == 0) wb_first = int'(wr_addr_b);
      wb_last = int'(wr_addr_b);
      wb_count++;
      check("b_wr_data", wr_data_b, res_row_b);
    end
  end

  // Present s[]/mbn to DUT A, wait for the handshake, update the model.
  task automatic submit(input int mbn);
    int n;
    int best;
    for (int k = 0; k < 4; k++) sads[k*16 +: 16] = 16'(s[k]);
    mbnumber = 12'(mbn);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("accept_timeout", in_ready, 1);
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    if (mbn >= 3600) begin
      exp_err++;
      check("err_mbnum_pulse", err_mbnum, 1);
      check("err_in_ready", in_ready, 1);
    end else begin
      best = 0;
      for (int k = 1; k < 4; k++) if (s[k] < s[best]) best = k;
      exp_q.push_back('{mode: best, sad: s[best], mbn: mbn});
      cur_mode    = best;
      mb_x        = mbn % 80;
      mb_y        = mbn / 80;
      mrow        = 0;
      mb_wr_count = 0;
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("idle_timeout", in_ready, 1);
  endtask

  task automatic set_sads(input int a, input int b, input int c, input int d);
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mv0, wr0, mbn;
    reset = 1'b1;
    in_valid = 1'b0; sads = '0; mbnumber = '0;
    in_valid_b = 1'b0; sads_b = '0; mbnumber_b = '0;
    res_valid_b = 1'b1;
    res_row_b = 72'h5A_1234_5678_9ABC_DEF0;
    mb_wr_count = 0; tot_wr = 0; mv_count = 0; err_count = 0; exp_err = 0;
    mrow = 0; cur_mode = 0; mb_x = 0; mb_y = 0; wb_count = 0;
    repeat (3) step();
    check("reset_ctl", {in_ready, res_ready, res_sel, wr_en, wr_addr, mode_valid,
                        mode, mode_sad, mode_mbnum, err_mbnum}, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_b_in_ready", in_ready_b, 0);
    mon_en = 1'b1;
    reset = 1'b0;
    step();
    check("in_ready_after_reset", in_ready, 1);

    // 1: tie resolves to the lower index; zero-wait latency
    gap = 0;
    set_sads(40, 25, 25, 90);
    submit(0);
    n = 1;
    while (mode_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("t1_latency", n, 20);
    check("t1_in_ready_done", in_ready, 0);
    step();
    check("t1_in_ready_next", in_ready, 1);
    check("t1_mode", mode, 1);
    check("t1_mode_sad", mode_sad, 25);
    check("t1_count", mb_wr_count, 16);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_addr", last_addr, 19200);

    // 2: interior macroblock addressing
    gap = 2;
    set_sads(300, 200, 100, 50);
    submit(81);
    wait_idle();
    check("t2_first_addr", first_addr, 20496);
    check("t2_last_addr", last_addr, 39696);
    check("t2_mode_mbnum", mode_mbnum, 81);
    check("t2_mode", mode, 3);

    // 3: out-of-range mbnumber is dropped
    mv0 = mv_count;
    wr0 = tot_wr;
    set_sads(1, 2, 3, 4);
    submit(3600);
    repeat (20) step();
    check("t3_no_mode_valid", mv_count, mv0);
    check("t3_no_writes", tot_wr, wr0);
    check("t3_in_ready", in_ready, 1);
    check("t3_err_count", err_count, 1);

    // 4: alternate-cycle residue gaps
    gap = 1;
    set_sads(9, 9, 3, 9);
    submit(1234);
    wait_idle();
    check("t4_count", mb_wr_count, 16);

    // 5: reset during FETCH aborts the MB
    gap = 0;
    set_sads(5, 6, 7, 1);
    submit(500);
    n = 0;
    while (mrow < 4 && n < 100) begin
      step();
      n++;
    end
    check("t5_reached_row4", mrow, 4);
    reset = 1'b1;
    step();
    exp_q.delete();
    check("t5_reset_ctl", {in_ready, res_ready, res_sel, wr_en, wr_addr, mode_valid,
                           mode, mode_sad, mode_mbnum, err_mbnum}, 0);
    check("t5_reset_wr_data", wr_data, 0);
    step();
    reset = 1'b0;
    step();
    check("t5_in_ready", in_ready, 1);
    set_sads(70, 60, 80, 65);
    submit(3599);
    wait_idle();
    check("t5_next_count", mb_wr_count, 16);
    check("t5_next_last_addr", last_addr, (44 * 16 + 15) * 1280 + 79 * 16);

    // randomized stream, back-to-back submissions, some ties and bad MBs
    for (int t = 0; t < 14; t++) begin
      gap = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++)
        s[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 7));
      mbn = ($urandom_range(0, 6) == 0) ? int'($urandom_range(3600, 4095)) : int'($urandom_range(0, 3599));
      submit(mbn);
    end
    wait_idle();
    repeat (3) step();
    check("rand_queue_drained", exp_q.size(), 0);
    check("err_total", err_count, exp_err);

    // 6: single mode, 8x8 macroblocks
    wb_count = 0;
    sads_b = 16'd77;
    mbnumber_b = 12'd161;
    in_valid_b = 1'b1;
    n = 0;
    while (in_ready_b !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("b_accept", in_ready_b, 1);
    step();
    in_valid_b = 1'b0;
    n = 1;
    while (mode_valid_b !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("b_latency", n, 9);
    check("b_mode", mode_b, 0);
    check("b_mode_sad", mode_sad_b, 77);
    check("b_mode_mbnum", mode_mbnum_b, 161);
    step();
    check("b_count", wb_count, 8);
    check("b_first_addr", wb_first, 10248);
    check("b_last_addr", wb_last, 19208);
    check("b_in_ready", in_ready_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
